// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle MIPS controller.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic       stall;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  stall, op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
           memtoreg, regdst, pcsrc, alucontrol, state
  );

  modport slave (
    output stall, op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
           memtoreg, regdst, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing MIPS lw/sw/R-type/beq/addi/j; outputs are combinational from state (plus zero/stall).
// stall freezes the state register and masks every write enable for that cycle.
module mips_multicycle_ctrl (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= FETCH;
    else if (!bus.stall)
      state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic       memwrite_raw;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] pcsrc;
  logic       bad_state;

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = 2'b00;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    iord         = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    pcsrc        = 2'b00;
    bad_state    = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB:  regwrite_raw = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: bad_state = 1'b1;
    endcase
  end

  logic [2:0] alu_ctl;

  // funct only matters for R-type; unknown functs select the ALU's invalid code
  always_comb begin
    alu_ctl = 3'b011;
    case (aluop)
      2'b00: alu_ctl = 3'b010;
      2'b01: alu_ctl = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100000: alu_ctl = 3'b010;
          6'b100010: alu_ctl = 3'b110;
          6'b100100: alu_ctl = 3'b000;
          6'b100101: alu_ctl = 3'b001;
          6'b101010: alu_ctl = 3'b111;
          default:   alu_ctl = 3'b011;
        endcase
      end
      default: alu_ctl = 3'b011;
    endcase
  end

  assign bus.pcen       = (pcwrite | (branch & bus.zero)) & ~bus.stall;
  assign bus.irwrite    = irwrite_raw  & ~bus.stall;
  assign bus.regwrite   = regwrite_raw & ~bus.stall;
  assign bus.memwrite   = memwrite_raw & ~bus.stall;
  assign bus.iord       = iord;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = bad_state ? 3'b000 : alu_ctl;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl; expected outputs queued per driven cycle, compared mid-cycle.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       stall;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    outs_t      exp;
    string      name;
  } vec_t;

  vec_t  tbl[$];
  outs_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Mux selects as listed per state; enables, state and alucontrol come from each vector.
  function automatic outs_t mk_exp(input logic [3:0] st, input logic pcen, input logic irw,
                                   input logic rw, input logic mw, input logic [2:0] aluc);
    outs_t o;
    o = '0;
    o.state = st;
    o.pcen = pcen;
    o.irwrite = irw;
    o.regwrite = rw;
    o.memwrite = mw;
    o.alucontrol = aluc;
    case (st)
      4'd0:       o.alusrcb = 2'b01;
      4'd1:       o.alusrcb = 2'b11;
      4'd2, 4'd9: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      4'd3:       o.iord = 1'b1;
      4'd4:       o.memtoreg = 1'b1;
      4'd5:       o.iord = 1'b1;
      4'd6:       o.alusrca = 1'b1;
      4'd7:       o.regdst = 1'b1;
      4'd8:       begin o.alusrca = 1'b1; o.pcsrc = 2'b01; end
      4'd11:      o.pcsrc = 2'b10;
      default:    ;
    endcase
    return o;
  endfunction

  function automatic vec_t mk(input logic rst, input logic stall, input logic [5:0] op,
                              input logic [5:0] fn, input logic z, input logic [3:0] st,
                              input logic pcen, input logic irw, input logic rw,
                              input logic mw, input logic [2:0] aluc, input string nm);
    vec_t v;
    v.rst = rst; v.stall = stall; v.op = op; v.funct = fn; v.zero = z;
    v.exp = mk_exp(st, pcen, irw, rw, mw, aluc);
    v.name = nm;
    return v;
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o.state = bus.state;
    o.pcen = bus.pcen;
    o.memwrite = bus.memwrite;
    o.irwrite = bus.irwrite;
    o.regwrite = bus.regwrite;
    o.iord = bus.iord;
    o.alusrca = bus.alusrca;
    o.alusrcb = bus.alusrcb;
    o.memtoreg = bus.memtoreg;
    o.regdst = bus.regdst;
    o.pcsrc = bus.pcsrc;
    o.alucontrol = bus.alucontrol;
    return o;
  endfunction

  task automatic check_out();
    outs_t got, want;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected record for sampled outputs");
      return;
    end
    want = exp_q.pop_front();
    nm = name_q.pop_front();
    got = observe();
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
               nm, got.state, got, want.state, want);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst;
    bus.stall = v.stall;
    bus.op = v.op;
    bus.funct = v.funct;
    bus.zero = v.zero;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clk);
    check_out();
  endtask

  // Fetch + decode prefix shared by every instruction.
  task automatic add_fd(input logic [5:0] op, input logic [5:0] fn, input logic z, input string nm);
    tbl.push_back(mk(0, 0, op, fn, z, 4'd0, 1, 1, 0, 0, 3'b010, {nm, "_fetch"}));
    tbl.push_back(mk(0, 0, op, fn, z, 4'd1, 0, 0, 0, 0, 3'b010, {nm, "_decode"}));
  endtask

  logic [5:0] fns[6];
  logic [2:0] acs[6];

  initial begin
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    acs = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011};

    // lw: 0,1,2,3,4
    add_fd(OP_LW, FN_ADD, 0, "lw");
    tbl.push_back(mk(0, 0, OP_LW, FN_ADD, 0, 4'd2, 0, 0, 0, 0, 3'b010, "lw_memadr"));
    tbl.push_back(mk(0, 0, OP_LW, FN_ADD, 0, 4'd3, 0, 0, 0, 0, 3'b010, "lw_memrd"));
    tbl.push_back(mk(0, 0, OP_LW, FN_ADD, 0, 4'd4, 0, 0, 1, 0, 3'b010, "lw_memwb"));
    // sw: 0,1,2,5
    add_fd(OP_SW, FN_ADD, 0, "sw");
    tbl.push_back(mk(0, 0, OP_SW, FN_ADD, 0, 4'd2, 0, 0, 0, 0, 3'b010, "sw_memadr"));
    tbl.push_back(mk(0, 0, OP_SW, FN_ADD, 0, 4'd5, 0, 0, 0, 1, 3'b010, "sw_memwr"));
    // R-type over every funct plus an unknown one
    for (int i = 0; i < 6; i++) begin
      add_fd(OP_R, fns[i], 0, "rtype");
      tbl.push_back(mk(0, 0, OP_R, fns[i], 0, 4'd6, 0, 0, 0, 0, acs[i], "rtype_ex_alucontrol"));
      tbl.push_back(mk(0, 0, OP_R, fns[i], 0, 4'd7, 0, 0, 1, 0, 3'b010, "rtype_wb"));
    end
    // beq taken / not taken
    add_fd(OP_BEQ, FN_ADD, 1, "beq_t");
    tbl.push_back(mk(0, 0, OP_BEQ, FN_ADD, 1, 4'd8, 1, 0, 0, 0, 3'b110, "beq_taken"));
    add_fd(OP_BEQ, FN_ADD, 0, "beq_nt");
    tbl.push_back(mk(0, 0, OP_BEQ, FN_ADD, 0, 4'd8, 0, 0, 0, 0, 3'b110, "beq_not_taken"));
    // addi and j
    add_fd(OP_ADDI, FN_ADD, 0, "addi");
    tbl.push_back(mk(0, 0, OP_ADDI, FN_ADD, 0, 4'd9, 0, 0, 0, 0, 3'b010, "addi_ex"));
    tbl.push_back(mk(0, 0, OP_ADDI, FN_ADD, 0, 4'd10, 0, 0, 1, 0, 3'b010, "addi_wb"));
    add_fd(OP_J, FN_ADD, 1, "j");
    tbl.push_back(mk(0, 0, OP_J, FN_ADD, 1, 4'd11, 1, 0, 0, 0, 3'b010, "j_ex"));
    // illegal opcodes fall straight back to fetch
    add_fd(OP_BAD, FN_ADD, 0, "illegal");
    add_fd(6'b000001, FN_ADD, 0, "illegal2");
    // stalls inside write states mask the enable and hold the state
    add_fd(OP_LW, FN_ADD, 0, "lw_st");
    tbl.push_back(mk(0, 0, OP_LW, FN_ADD, 0, 4'd2, 0, 0, 0, 0, 3'b010, "lw_st_memadr"));
    tbl.push_back(mk(0, 0, OP_LW, FN_ADD, 0, 4'd3, 0, 0, 0, 0, 3'b010, "lw_st_memrd"));
    tbl.push_back(mk(0, 1, OP_LW, FN_ADD, 0, 4'd4, 0, 0, 0, 0, 3'b010, "memwb_stalled"));
    tbl.push_back(mk(0, 0, OP_LW, FN_ADD, 0, 4'd4, 0, 0, 1, 0, 3'b010, "memwb_after_stall"));
    add_fd(OP_SW, FN_ADD, 0, "sw_st");
    tbl.push_back(mk(0, 1, OP_SW, FN_ADD, 0, 4'd2, 0, 0, 0, 0, 3'b010, "memadr_stalled"));
    tbl.push_back(mk(0, 0, OP_SW, FN_ADD, 0, 4'd2, 0, 0, 0, 0, 3'b010, "memadr_after_stall"));
    tbl.push_back(mk(0, 1, OP_SW, FN_ADD, 0, 4'd5, 0, 0, 0, 0, 3'b010, "memwr_stalled"));
    tbl.push_back(mk(0, 0, OP_SW, FN_ADD, 0, 4'd5, 0, 0, 0, 1, 3'b010, "memwr_after_stall"));
    add_fd(OP_BEQ, FN_ADD, 1, "beq_st");
    tbl.push_back(mk(0, 1, OP_BEQ, FN_ADD, 1, 4'd8, 0, 0, 0, 0, 3'b110, "beq_stalled"));
    tbl.push_back(mk(0, 0, OP_BEQ, FN_ADD, 1, 4'd8, 1, 0, 0, 0, 3'b110, "beq_after_stall"));

    reset = 1'b1;
    bus.stall = 1'b0;
    bus.op = OP_R;
    bus.funct = FN_ADD;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    apply(mk(1, 0, OP_LW, FN_ADD, 0, 4'd0, 1, 1, 0, 0, 3'b010, "reset_state"));

    foreach (tbl[i]) apply(tbl[i]);

    // Three-cycle stall in FETCH, then progress on the edge after release.
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, OP_LW, FN_ADD, 0, 4'd0, 0, 0, 0, 0, 3'b010, "fetch_stalled"));
    apply(mk(0, 0, OP_LW, FN_ADD, 0, 4'd0, 1, 1, 0, 0, 3'b010, "fetch_released"));
    apply(mk(0, 0, OP_LW, FN_ADD, 0, 4'd1, 0, 0, 0, 0, 3'b010, "decode_after_stall"));
    // Reset in MEMRD aborts the load before its writeback.
    apply(mk(0, 0, OP_LW, FN_ADD, 0, 4'd2, 0, 0, 0, 0, 3'b010, "abort_memadr"));
    apply(mk(1, 0, OP_LW, FN_ADD, 0, 4'd3, 0, 0, 0, 0, 3'b010, "abort_memrd"));
    apply(mk(0, 0, OP_R, FN_ADD, 0, 4'd0, 1, 1, 0, 0, 3'b010, "abort_to_fetch"));
    // Reset wins over stall.
    apply(mk(0, 0, OP_R, FN_ADD, 0, 4'd1, 0, 0, 0, 0, 3'b010, "rs_decode"));
    apply(mk(1, 1, OP_R, FN_ADD, 0, 4'd6, 0, 0, 0, 0, 3'b010, "rs_rtypeex"));
    apply(mk(0, 0, OP_R, FN_ADD, 0, 4'd0, 1, 1, 0, 0, 3'b010, "reset_beats_stall"));

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
